// File: rtl/color_row_scheduler.sv
// Spawn-path sequencer: waits for the randomizer to settle after a game tick, screens sampled
// rows against the spawn rules, and presents the accepted row over a valid/ready handshake.
module color_row_scheduler #(
    parameter int SETTLE_CYC = 2,
    parameter int MAX_RETRY  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            game_tick,
    input  logic            pause,
    input  logic [0:4][2:0] random_color,
    input  logic            row_ready,
    output logic            row_valid,
    output logic [0:4][2:0] row_colors,
    output logic [7:0]      row_count,
    output logic            forced,
    output logic            tick_dropped,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, PRESENT} state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC);
    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

    state_t          state, state_n;
    logic [3:0]      cnt, cnt_n;
    logic [2:0]      retries, retries_n;
    logic            pending, pending_n;
    logic            dropped_n;
    logic [0:4][2:0] cand, prev;
    logic            capture, load_row, force_row, release_row;
    logic            bad_lane, all_equal, cand_bad;

    always_comb begin
        bad_lane  = 1'b0;
        all_equal = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (cand[i] == 3'b000 || cand[i] == 3'b111)
                bad_lane = 1'b1;
            if (cand[i] != cand[0])
                all_equal = 1'b0;
        end
        cand_bad = bad_lane || all_equal || (cand == prev);
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        retries_n   = retries;
        pending_n   = pending;
        dropped_n   = tick_dropped;
        capture     = 1'b0;
        load_row    = 1'b0;
        force_row   = 1'b0;
        release_row = 1'b0;

        // Ticks are recorded whenever the FSM cannot start on them right away, including while paused
        if (game_tick && (state != IDLE || pause)) begin
            if (pending)
                dropped_n = 1'b1;
            else
                pending_n = 1'b1;
        end

        if (!pause) begin
            case (state)
                IDLE: begin
                    if (pending || game_tick) begin
                        state_n   = SETTLE;
                        cnt_n     = SETTLE_INIT;
                        retries_n = 3'd0;
                        // A fresh tick arriving alongside a pending one stays queued
                        pending_n = pending && game_tick;
                    end
                end
                SETTLE: begin
                    if (cnt != 4'd0) begin
                        cnt_n = cnt - 4'd1;
                    end else begin
                        capture = 1'b1;
                        state_n = CHECK;
                    end
                end
                CHECK: begin
                    if (!cand_bad) begin
                        load_row = 1'b1;
                        state_n  = PRESENT;
                    end else if (retries < RETRY_LIMIT) begin
                        retries_n = retries + 3'd1;
                        cnt_n     = 4'd0;
                        state_n   = SETTLE;
                    end else begin
                        load_row  = 1'b1;
                        force_row = 1'b1;
                        state_n   = PRESENT;
                    end
                end
                PRESENT: begin
                    if (row_valid && row_ready) begin
                        release_row = 1'b1;
                        state_n     = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            retries      <= 3'd0;
            pending      <= 1'b0;
            tick_dropped <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            retries      <= retries_n;
            pending      <= pending_n;
            tick_dropped <= dropped_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand       <= '0;
            prev       <= '0;
            row_colors <= '0;
            row_valid  <= 1'b0;
            forced     <= 1'b0;
            row_count  <= 8'd0;
        end else begin
            if (capture)
                cand <= random_color;
            if (load_row) begin
                row_colors <= cand;
                prev       <= cand;
                row_valid  <= 1'b1;
                forced     <= force_row;
                row_count  <= row_count + 8'd1;
            end else if (release_row) begin
                row_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_color_row_scheduler.sv
// Directed bench for color_row_scheduler: expected rows go into a scoreboard queue when a tick
// is issued and are compared against the DUT when the handshake completes.
module tb_color_row_scheduler;

    localparam logic [14:0] ROW_A = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    localparam logic [14:0] ROW_B = {3'd6, 3'd5, 3'd4, 3'd3, 3'd2};
    localparam logic [14:0] ROW_C = {3'd5, 3'd5, 3'd5, 3'd5, 3'd5};
    localparam logic [14:0] ROW_D = {3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    localparam logic [14:0] ROW_E = {3'd3, 3'd4, 3'd5, 3'd6, 3'd1};
    localparam logic [14:0] ROW_F = {3'd4, 3'd5, 3'd6, 3'd1, 3'd2};

    logic            clk = 1'b0;
    logic            rst;
    logic            game_tick;
    logic            pause;
    logic [0:4][2:0] random_color;
    logic            row_ready;
    logic            row_valid;
    logic [0:4][2:0] row_colors;
    logic [7:0]      row_count;
    logic            forced;
    logic            tick_dropped;
    logic            busy;

    int          checkCount = 0;
    int          passCount  = 0;
    int          failCount  = 0;
    logic [15:0] expQ[$];

    always #5 clk = ~clk;

    color_row_scheduler #(.SETTLE_CYC(2), .MAX_RETRY(3)) dut (
        .clk(clk),
        .rst(rst),
        .game_tick(game_tick),
        .pause(pause),
        .random_color(random_color),
        .row_ready(row_ready),
        .row_valid(row_valid),
        .row_colors(row_colors),
        .row_count(row_count),
        .forced(forced),
        .tick_dropped(tick_dropped),
        .busy(busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [14:0] bus, input logic pulse);
        random_color = bus;
        game_tick    = pulse;
        cycle();
        game_tick    = 1'b0;
    endtask

    task automatic waitValid(output int n);
        n = 0;
        while (!row_valid && n < 40) begin
            cycle();
            n++;
        end
    endtask

    // Scoreboard: every completed handshake must match the oldest expected row
    always @(negedge clk) begin
        if (!rst && row_valid && row_ready && !pause) begin
            logic [15:0] exp;
            exp = (expQ.size() != 0) ? expQ.pop_front() : 16'hxxxx;
            checkOutput("sb_colors", 32'(row_colors), 32'(exp[14:0]));
            checkOutput("sb_forced", 32'(forced), 32'(exp[15]));
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int total;
        logic [14:0] bus;

        rst          = 1'b1;
        game_tick    = 1'b0;
        pause        = 1'b0;
        row_ready    = 1'b1;
        random_color = ROW_A;
        repeat (3) cycle();
        checkOutput("rst_valid", 32'(row_valid), 32'd0);
        checkOutput("rst_colors", 32'(row_colors), 32'd0);
        checkOutput("rst_count", 32'(row_count), 32'd0);
        checkOutput("rst_forced", 32'(forced), 32'd0);
        checkOutput("rst_dropped", 32'(tick_dropped), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (6) cycle();

        // First row passes on the first sample
        expQ.push_back({1'b0, ROW_A});
        applyStimulus(ROW_A, 1'b1);
        checkOutput("busy_after_tick", 32'(busy), 32'd1);
        waitValid(n);
        checkOutput("first_latency", 32'(n), 32'd4);
        checkOutput("first_colors", 32'(row_colors), 32'(ROW_A));
        checkOutput("first_count", 32'(row_count), 32'd1);
        checkOutput("first_forced", 32'(forced), 32'd0);
        cycle();
        checkOutput("first_released", 32'(row_valid), 32'd0);
        checkOutput("first_idle", 32'(busy), 32'd0);

        // Duplicate of the previous row forces one retry
        expQ.push_back({1'b0, ROW_B});
        applyStimulus(ROW_A, 1'b1);
        repeat (3) cycle();
        random_color = ROW_B;
        waitValid(n);
        total = n + 3;
        checkOutput("retry_latency", 32'(total), 32'd6);
        checkOutput("retry_colors", 32'(row_colors), 32'(ROW_B));
        checkOutput("retry_count", 32'(row_count), 32'd2);
        cycle();

        // Uniform row is rejected every time and finally forced out
        expQ.push_back({1'b1, ROW_C});
        applyStimulus(ROW_C, 1'b1);
        waitValid(n);
        checkOutput("forced_latency", 32'(n), 32'd10);
        checkOutput("forced_flag", 32'(forced), 32'd1);
        checkOutput("forced_colors", 32'(row_colors), 32'(ROW_C));
        checkOutput("forced_count", 32'(row_count), 32'd3);
        cycle();

        // Backpressure: extra ticks while presenting, one queued and one dropped
        row_ready = 1'b0;
        expQ.push_back({1'b0, ROW_D});
        applyStimulus(ROW_D, 1'b1);
        waitValid(n);
        checkOutput("bp_latency", 32'(n), 32'd4);
        applyStimulus(ROW_D, 1'b1);
        checkOutput("bp_dropped_first", 32'(tick_dropped), 32'd0);
        checkOutput("bp_valid_held", 32'(row_valid), 32'd1);
        applyStimulus(ROW_D, 1'b1);
        checkOutput("bp_dropped_second", 32'(tick_dropped), 32'd1);
        applyStimulus(ROW_D, 1'b1);
        checkOutput("bp_colors_stable", 32'(row_colors), 32'(ROW_D));
        checkOutput("bp_busy", 32'(busy), 32'd1);
        expQ.push_back({1'b0, ROW_E});
        random_color = ROW_E;
        row_ready    = 1'b1;
        n = 0;
        while (row_count != 8'd5 && n < 40) begin
            cycle();
            n++;
        end
        checkOutput("bp_followup_count", 32'(row_count), 32'd5);
        repeat (20) cycle();
        checkOutput("bp_single_followup", 32'(row_count), 32'd5);
        checkOutput("bp_idle", 32'(busy), 32'd0);

        // Pause in SETTLE stretches latency by exactly the paused cycles
        expQ.push_back({1'b0, ROW_F});
        applyStimulus(ROW_F, 1'b1);
        pause = 1'b1;
        repeat (5) cycle();
        checkOutput("pause_busy", 32'(busy), 32'd1);
        checkOutput("pause_no_valid", 32'(row_valid), 32'd0);
        pause = 1'b0;
        waitValid(n);
        total = n + 5;
        checkOutput("pause_latency", 32'(total), 32'd9);
        checkOutput("pause_count", 32'(row_count), 32'd6);
        cycle();

        // Reset while a row is presented discards it without a handshake
        row_ready = 1'b0;
        applyStimulus(ROW_A, 1'b1);
        waitValid(n);
        checkOutput("midrst_presented", 32'(row_valid), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", 32'(row_valid), 32'd0);
        checkOutput("midrst_count", 32'(row_count), 32'd0);
        checkOutput("midrst_dropped", 32'(tick_dropped), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        cycle();
        rst       = 1'b0;
        row_ready = 1'b1;
        cycle();

        // 256 accepted rows wrap the counter back to zero
        for (int i = 0; i < 256; i++) begin
            bus = i[0] ? ROW_B : ROW_A;
            expQ.push_back({1'b0, bus});
            applyStimulus(bus, 1'b1);
            n = 0;
            while (busy && n < 30) begin
                cycle();
                n++;
            end
            if (i == 254)
                checkOutput("wrap_count_255", 32'(row_count), 32'd255);
        end
        checkOutput("wrap_count_zero", 32'(row_count), 32'd0);

        repeat (5) cycle();
        checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
